// File: rtl/rate_mult_bank_if.sv
// Rate-word load port for rate_mult_bank: a valid/ready handshake that carries
// the target channel and the new rate word.
interface rate_mult_bank_if #(
    parameter int WIDTH = 8,
    parameter int CHW   = 2
);
    logic             rate_valid;
    logic             rate_ready;
    logic [CHW-1:0]   rate_ch;
    logic [WIDTH-1:0] rate_data;

    modport master (
        output rate_valid,
        output rate_ch,
        output rate_data,
        input  rate_ready
    );

    modport slave (
        input  rate_valid,
        input  rate_ch,
        input  rate_data,
        output rate_ready
    );
endinterface

// File: rtl/rate_mult_bank.sv
// Multi-channel binary rate multiplier. One shared up-counter Y advances on X;
// each channel emits exactly C[ch] pulses per 2^WIDTH enabled cycles. New rate
// words are staged in a shadow register and only become active at counter wrap,
// so every period is an exact one.
module rate_mult_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CK,
    input  logic                Reset,
    input  logic                X,
    input  logic                Clear,
    rate_mult_bank_if.slave     rate,
    output logic [WIDTH-1:0]    Y,
    output logic                W,
    output logic [CHANNELS-1:0] Z,
    output logic [CHANNELS-1:0] pending
);

    logic [WIDTH-1:0]    rate_c [CHANNELS];
    logic [WIDTH-1:0]    rate_s [CHANNELS];
    logic [WIDTH-1:0]    first_zero;
    logic [CHANNELS-1:0] pulse_next;
    logic                all_ones;
    logic                wrap;
    logic                load_fire;

    // The port only refuses loads while Reset is being applied.
    assign rate.rate_ready = ~Reset;
    assign load_fire       = rate.rate_valid & rate.rate_ready;
    assign all_ones        = &Y;
    assign wrap            = X & all_ones;

    // Pulse decision: the lowest zero bit of Y sits at position k (the number
    // of trailing ones), and channel ch pulses when C[ch][WIDTH-1-k] is set.
    // ~Y & (Y+1) is one-hot on that bit and zero when Y is all ones, which
    // gives the "no pulse on the wrap cycle" case for free.
    always_comb begin
        first_zero = ~Y & (Y + WIDTH'(1));
        pulse_next = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int i = 0; i < WIDTH; i++) begin
                pulse_next[ch] = pulse_next[ch] | (rate_c[ch][WIDTH-1-i] & first_zero[i]);
            end
        end
    end

    // Counter, registered outputs and the shadow/active rate registers.
    always_ff @(posedge CK) begin
        if (Reset) begin
            Y       <= '0;
            Z       <= '0;
            W       <= 1'b0;
            pending <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                rate_c[ch] <= '0;
                rate_s[ch] <= '0;
            end
        end else begin
            if (Clear) begin
                Y <= '0;
                Z <= '0;
                W <= 1'b0;
            end else begin
                if (X) begin
                    Y <= Y + WIDTH'(1);
                end
                Z <= X ? pulse_next : '0;
                W <= wrap;
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
                // The old shadow word is promoted first so that a load landing
                // on the wrap cycle stays pending for the following wrap.
                if (!Clear && wrap && pending[ch]) begin
                    rate_c[ch]  <= rate_s[ch];
                    pending[ch] <= 1'b0;
                end
                if (load_fire && (rate.rate_ch == CHW'(ch))) begin
                    rate_s[ch]  <= rate.rate_data;
                    pending[ch] <= 1'b1;
                end
            end
        end
    end

endmodule
